// File: rtl/grng_pkg.sv
// Shared definitions for the ICDF Gaussian issue controller.
//   - state_t        : run-controller states
//   - URNG field map : leading-zero field [63:18], mask segment [17:3]
//   - lzc()          : leading-zero count of the [63:18] field (0..46)
package grng_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int URNG_W = 64;
   localparam int LZ_LO  = 18;
   localparam int SEG_HI = 17;
   localparam int SEG_LO = 3;
   localparam int LZ_W   = URNG_W - LZ_LO;   // 46-bit leading-zero field

   localparam logic [5:0] ZPOS_MAX = 6'd63;
   localparam logic [5:0] ZPOS_MIN = 6'd17;

   // Leading zeros of the field; an all-zero field counts as LZ_W.
   // Scanning upward lets the highest set bit overwrite lower ones.
   function automatic logic [5:0] lzc(input logic [LZ_W-1:0] f);
      logic [5:0] n;
      n = 6'(LZ_W);
      for (int i = 0; i < LZ_W; i++) begin
         if (f[i]) n = 6'(LZ_W - 1 - i);
      end
      return n;
   endfunction

endpackage

// File: rtl/grng_issue_ctrl_if.sv
// Valid/ready stream bundle used for both the URNG input and the sample output.
//   valid : producer has data
//   ready : consumer accepts data
//   data  : payload, W bits
interface grng_issue_ctrl_if #(
   parameter int W = 16
) ();
   logic         valid;
   logic         ready;
   logic [W-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/grng_smp_fifo.sv
// First-word-fall-through sample FIFO.
//   clk, rst (async, active-low)
//   wr_en/wr_data : push
//   rd_en/rd_data : pop; rd_data shows the head whenever count != 0
//   count         : current occupancy (0..DEPTH)
module grng_smp_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [W-1:0]               wr_data,
   input  logic                       rd_en,
   output logic [W-1:0]               rd_data,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [AW-1:0] C_ONE_AW = AW'(1);
   localparam logic [CW-1:0] C_ONE_CW = CW'(1);
   localparam logic [CW-1:0] C_FULL   = CW'(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_do_rd;
   logic          w_full;

   assign w_full  = (r_count == C_FULL);
   assign w_do_rd = rd_en && (r_count != '0);
   assign rd_data = r_mem[r_rd_ptr];
   assign count   = r_count;

   // Storage carries no reset: stale words are unreachable once pointers clear.
   always_ff @(posedge clk) begin
      if (wr_en) r_mem[r_wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (wr_en)   r_wr_ptr <= r_wr_ptr + C_ONE_AW;
         if (w_do_rd) r_rd_ptr <= r_rd_ptr + C_ONE_AW;
         case ({wr_en, w_do_rd})
            2'b10:   r_count <= r_count + C_ONE_CW;
            2'b01:   r_count <= r_count - C_ONE_CW;
            default: ;
         endcase
      end
   end

   // Issue credits make a write into a full FIFO impossible; flag it if it happens.
   a_no_overflow : assert property (@(posedge clk) disable iff (!rst) !(wr_en && w_full))
      else $error("grng_smp_fifo: write while full");

endmodule

// File: rtl/grng_issue_ctrl.sv
// Run controller and credit scheduler for the ICDF Gaussian pipeline.
//   clk, rst (async, active-low)
//   start/stop/cfg_num : run control; cfg_num==0 runs until stop
//   busy/done          : status; done pulses for one cycle at end of run
//   urng (slave)       : 64-bit URNG words in
//   en_mask/zero_pos/urng_seg3 : registered mask-stage inputs
//   pipe_data          : datapath tail, valid PIPE_LAT edges after issue
//   smp (master)       : finished samples out of the FWFT FIFO
module grng_issue_ctrl
   import grng_pkg::*;
#(
   parameter int PIPE_LAT   = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int OUT_W      = 16,
   parameter int NUM_W      = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic [NUM_W-1:0]   cfg_num,
   output logic               busy,
   output logic               done,
   grng_issue_ctrl_if.slave   urng,
   output logic               en_mask,
   output logic [5:0]         zero_pos,
   output logic [14:0]        urng_seg3,
   input  logic [OUT_W-1:0]   pipe_data,
   grng_issue_ctrl_if.master  smp
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0]    C_ONE_CW  = CW'(1);
   localparam logic [CW:0]      C_DEPTH   = (CW+1)'(FIFO_DEPTH);
   localparam logic [NUM_W-1:0] C_ONE_NUM = NUM_W'(1);

   state_t              r_state;
   state_t              w_state_next;
   logic [NUM_W-1:0]    r_remaining;
   logic                r_cont;
   logic [CW-1:0]       r_inflight;
   logic [PIPE_LAT-1:0] r_tok;
   logic                r_en_mask;
   logic [5:0]          r_zero_pos;
   logic [14:0]         r_urng_seg3;

   logic [CW-1:0]       w_fifo_count;
   logic [CW:0]         w_used;
   logic                w_ready;
   logic                w_fire;
   logic                w_capture;
   logic                w_smp_valid;

   // Every issued word is either still in the pipe or already in the FIFO,
   // so issuing only while that total is below the depth can never overflow.
   assign w_used      = {1'b0, w_fifo_count} + {1'b0, r_inflight};
   assign w_ready     = (r_state == RUN) && (w_used < C_DEPTH) && (r_cont || (r_remaining != '0));
   assign w_fire      = urng.valid && w_ready;
   assign w_capture   = r_tok[PIPE_LAT-1];
   assign w_smp_valid = (w_fifo_count != '0);

   assign urng.ready = w_ready;
   assign smp.valid  = w_smp_valid;
   assign busy       = (r_state != IDLE);
   assign done       = (r_state == DONE);
   assign en_mask    = r_en_mask;
   assign zero_pos   = r_zero_pos;
   assign urng_seg3  = r_urng_seg3;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:  if (start) w_state_next = RUN;
         RUN:   if (stop || (w_fire && !r_cont && (r_remaining == C_ONE_NUM)))
                   w_state_next = FLUSH;
         FLUSH: if ((r_inflight == '0) && !w_capture) w_state_next = DONE;
         DONE:  w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_remaining <= '0;
         r_cont      <= 1'b0;
         r_inflight  <= '0;
         r_tok       <= '0;
         r_en_mask   <= 1'b0;
         r_zero_pos  <= '0;
         r_urng_seg3 <= '0;
      end else begin
         if ((r_state == IDLE) && start) begin
            r_remaining <= cfg_num;
            r_cont      <= (cfg_num == '0);
         end else if (w_fire && !r_cont) begin
            r_remaining <= r_remaining - C_ONE_NUM;
         end

         case ({w_fire, w_capture})
            2'b10:   r_inflight <= r_inflight + C_ONE_CW;
            2'b01:   r_inflight <= r_inflight - C_ONE_CW;
            default: ;
         endcase

         // Token tracks each issued word down the fixed-latency datapath.
         r_tok     <= {r_tok[PIPE_LAT-2:0], w_fire};
         r_en_mask <= w_fire;
         if (w_fire) begin
            r_zero_pos  <= ZPOS_MAX - lzc(urng.data[URNG_W-1:LZ_LO]);
            r_urng_seg3 <= urng.data[SEG_HI:SEG_LO];
         end
      end
   end

   grng_smp_fifo #(
      .W     (OUT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (w_capture),
      .wr_data (pipe_data),
      .rd_en   (smp.ready),
      .rd_data (smp.data),
      .count   (w_fifo_count)
   );

endmodule

// File: tb/tb_grng_issue_ctrl.sv
// Scoreboard bench for grng_issue_ctrl: random URNG words, a behavioural
// zero-position model, a stand-in 3-register datapath and a decoupled monitor.
module tb_grng_issue_ctrl;
   localparam int PIPE_LAT   = 4;
   localparam int FIFO_DEPTH = 8;
   localparam int OUT_W      = 16;
   localparam int NUM_W      = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic             stop = 1'b0;
   logic [NUM_W-1:0] cfg_num = '0;
   logic             busy, done, en_mask;
   logic [5:0]       zero_pos;
   logic [14:0]      urng_seg3;
   logic [OUT_W-1:0] pipe_data;

   grng_issue_ctrl_if #(.W(64))    urng_if ();
   grng_issue_ctrl_if #(.W(OUT_W)) smp_if ();

   always #5 clk = ~clk;

   grng_issue_ctrl #(
      .PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(FIFO_DEPTH), .OUT_W(OUT_W), .NUM_W(NUM_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .cfg_num(cfg_num),
      .busy(busy), .done(done), .urng(urng_if), .en_mask(en_mask),
      .zero_pos(zero_pos), .urng_seg3(urng_seg3), .pipe_data(pipe_data), .smp(smp_if)
   );

   // Stand-in datapath: mask-stage registers plus three stages -> valid PIPE_LAT edges after issue.
   logic [OUT_W-1:0] s1, s2, s3;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1 <= '0; s2 <= '0; s3 <= '0;
      end else begin
         s1 <= en_mask ? {zero_pos, urng_seg3[9:0]} : '0;
         s2 <= s1;
         s3 <= s2;
      end
   end
   assign pipe_data = s3;

   typedef struct { logic [OUT_W-1:0] v; int c; } exp_t;
   exp_t        exp_q[$];
   logic [63:0] forced_q[$];
   int checks = 0, failures = 0;
   int cyc = 0, issue_tot = 0, pop_tot = 0, done_tot = 0, occ = 0;
   bit lat_exact = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Position of the highest set bit in [63:18]; 17 when none is set.
   function automatic int ref_zpos(input logic [63:0] d);
      for (int b = 63; b >= 18; b--) if (d[b]) return b;
      return 17;
   endfunction

   task automatic check_v(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s got=%0h required=%0h @cyc %0d", name, act, req, cyc);
      end
   endtask

   // Monitor / scoreboard
   initial begin
      bit          prev_fire;
      logic [5:0]  prev_zp;
      logic [14:0] prev_seg;
      int          zp;
      exp_t        e;
      prev_fire = 1'b0; prev_zp = '0; prev_seg = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            exp_q.delete();
            occ = 0;
            prev_fire = 1'b0;
         end else begin
            check_v("en_mask", en_mask, prev_fire);
            if (prev_fire) begin
               check_v("zero_pos", zero_pos, prev_zp);
               check_v("urng_seg3", urng_seg3, prev_seg);
            end
            if (done) done_tot++;
            if (urng_if.ready) check_v("credit_ok", occ < FIFO_DEPTH, 1);
            if (smp_if.valid && smp_if.ready) begin
               if (exp_q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_sample got=%0h required=none @cyc %0d", smp_if.data, cyc);
               end else begin
                  e = exp_q.pop_front();
                  check_v("smp_data", smp_if.data, e.v);
                  if (lat_exact) check_v("latency", cyc - e.c, PIPE_LAT + 1);
                  else           check_v("latency_min", (cyc - e.c) >= PIPE_LAT + 1, 1);
                  $display("sample %0d data=%h latency=%0d", pop_tot, smp_if.data, cyc - e.c);
               end
               pop_tot++;
               occ--;
            end
            prev_fire = urng_if.valid && urng_if.ready;
            if (prev_fire) begin
               zp       = ref_zpos(urng_if.data);
               prev_zp  = 6'(zp);
               prev_seg = urng_if.data[17:3];
               exp_q.push_back('{v: {prev_zp, prev_seg[9:0]}, c: cyc});
               occ++;
               issue_tot++;
            end
         end
      end
   end

   // Stimulus
   int seen_issue = 0;

   function automatic logic [63:0] next_word();
      logic [63:0] r;
      if (forced_q.size() != 0) return forced_q.pop_front();
      r = {$urandom(), $urandom()};
      return r >> $urandom_range(0, 63);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (issue_tot != seen_issue) begin
         seen_issue = issue_tot;
         urng_if.data = next_word();
      end
   endtask

   task automatic wait_done(input string tag);
      int d0, k;
      d0 = done_tot; k = 0;
      while (done_tot == d0 && k < 500) begin tick(); k++; end
      check_v({tag, "_done_seen"}, done_tot != d0, 1);
      tick(); tick();
      check_v({tag, "_done_once"}, done_tot - d0, 1);
      check_v({tag, "_busy_after"}, busy, 0);
   endtask

   task automatic drain(input string tag);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 300) begin tick(); k++; end
      check_v({tag, "_drained"}, exp_q.size(), 0);
   endtask

   initial begin
      int ib, pb, d0, k;
      urng_if.valid = 1'b0;
      urng_if.data  = '0;
      smp_if.ready  = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_v("rst_busy", busy, 0);
      check_v("rst_done", done, 0);
      check_v("rst_urng_ready", urng_if.ready, 0);
      check_v("rst_en_mask", en_mask, 0);
      check_v("rst_smp_valid", smp_if.valid, 0);
      check_v("rst_zero_pos", zero_pos, 0);
      check_v("rst_seg3", urng_seg3, 0);
      rst = 1'b1;
      tick();

      // Counted run of 3, with a start re-pulse during RUN that must be ignored
      forced_q.push_back(64'h8000_0000_0004_0008);
      forced_q.push_back(64'h0000_0000_0000_0008);
      urng_if.data = next_word();
      lat_exact = 1'b1;
      ib = issue_tot; pb = pop_tot;
      smp_if.ready = 1'b1; urng_if.valid = 1'b1; cfg_num = 16'd3; start = 1'b1;
      tick(); start = 1'b0;
      tick(); start = 1'b1; cfg_num = 16'd9;
      tick(); start = 1'b0;
      wait_done("t1");
      check_v("t1_issues", issue_tot - ib, 3);
      drain("t1");
      check_v("t1_pops", pop_tot - pb, 3);
      lat_exact = 1'b0;

      // Backpressure: continuous run, no downstream ready
      ib = issue_tot; pb = pop_tot;
      smp_if.ready = 1'b0; cfg_num = '0; start = 1'b1;
      tick(); start = 1'b0;
      repeat (20) tick();
      check_v("bp_issues", issue_tot - ib, FIFO_DEPTH);
      check_v("bp_ready_low", urng_if.ready, 0);
      check_v("bp_smp_valid", smp_if.valid, 1);
      smp_if.ready = 1'b1;
      repeat (12) tick();
      check_v("bp_resume", (issue_tot - ib) > FIFO_DEPTH, 1);
      stop = 1'b1;
      tick(); stop = 1'b0;
      wait_done("bp");
      drain("bp");
      check_v("bp_no_loss", pop_tot - pb, issue_tot - ib);

      // Stop with two words in flight
      ib = issue_tot; pb = pop_tot;
      cfg_num = 16'd100; start = 1'b1;
      tick(); start = 1'b0;
      k = 0;
      while ((issue_tot - ib) < 2 && k < 50) begin tick(); k++; end
      urng_if.valid = 1'b0; stop = 1'b1; start = 1'b1;
      tick(); stop = 1'b0; start = 1'b0;
      check_v("stop_ready_drop", urng_if.ready, 0);
      check_v("stop_busy", busy, 1);
      wait_done("stop");
      check_v("stop_issues", issue_tot - ib, 2);
      drain("stop");
      check_v("stop_pops", pop_tot - pb, 2);

      // Asynchronous reset with words in flight
      ib = issue_tot;
      urng_if.valid = 1'b1; smp_if.ready = 1'b0; cfg_num = '0; start = 1'b1;
      tick(); start = 1'b0;
      k = 0;
      while ((issue_tot - ib) < 3 && k < 50) begin tick(); k++; end
      d0 = done_tot;
      #2 rst = 1'b0;
      #1;
      check_v("arst_busy", busy, 0);
      check_v("arst_done", done, 0);
      check_v("arst_urng_ready", urng_if.ready, 0);
      check_v("arst_en_mask", en_mask, 0);
      check_v("arst_smp_valid", smp_if.valid, 0);
      check_v("arst_zero_pos", zero_pos, 0);
      check_v("arst_seg3", urng_seg3, 0);
      urng_if.valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (3) tick();
      check_v("arst_no_done", done_tot, d0);

      // Single-sample run after reset
      ib = issue_tot; pb = pop_tot;
      urng_if.valid = 1'b1; smp_if.ready = 1'b1; cfg_num = 16'd1; start = 1'b1;
      tick(); start = 1'b0;
      wait_done("one");
      check_v("one_issues", issue_tot - ib, 1);
      drain("one");
      repeat (6) tick();
      check_v("one_pops", pop_tot - pb, 1);
      check_v("one_smp_valid", smp_if.valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
